// File: rtl/key_debouncer.sv
// Push-button debouncer: 2-FF synchronizer, stability filter and auto-repeat per key.
// Outputs are registered; press/release are single-cycle pulses.
`timescale 1ns/1ps
module key_debouncer #(
  parameter int KEYS          = 2,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic            clk100_i,
  input  logic            rst_i,
  input  logic [KEYS-1:0] key_i,
  output logic [KEYS-1:0] key_level_o,
  output logic [KEYS-1:0] key_press_o,
  output logic [KEYS-1:0] key_release_o
);

  localparam int MAX_A = (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  // Raw lines idle high, so the synchronizer resets to "released".
  logic [KEYS-1:0] meta_q, sync_q;

  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= key_i;
      sync_q <= meta_q;
    end
  end

  for (genvar g = 0; g < KEYS; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          s;

    assign s = ~sync_q[g];

    always_ff @(posedge clk100_i or posedge rst_i) begin
      if (rst_i) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          level_d = 1'b0;
          if (s) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end else if (REPEAT_EN != 0 && cnt_q == DELAY_LAST) begin
            state_d = REPEAT;
            cnt_d   = '0;
            press_d = 1'b1;
          end else if (cnt_q != '1) begin
            // Saturate so a long hold without repeat never wraps.
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == PERIOD_LAST) begin
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            // Bounce back to pressed restarts the repeat delay from zero.
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign key_level_o[g]   = level_q;
    assign key_press_o[g]   = press_q;
    assign key_release_o[g] = release_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: two instances (repeat off / on) checked every cycle
// against an edge-counting model, plus literal pulse-timing checks per scenario.
`timescale 1ns/1ps
module tb_key_debouncer;
  localparam int SC = 4;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_n = 2'b11;
  logic [1:0] lvl0, pr0, rl0, lvl1, pr1, rl1;

  key_debouncer #(.KEYS(2), .STABLE_CYCLES(SC), .REPEAT_EN(0),
                  .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_norep (
    .clk100_i(clk), .rst_i(rst), .key_i(key_n),
    .key_level_o(lvl0), .key_press_o(pr0), .key_release_o(rl0));

  key_debouncer #(.KEYS(2), .STABLE_CYCLES(SC), .REPEAT_EN(1),
                  .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_rep (
    .clk100_i(clk), .rst_i(rst), .key_i(key_n),
    .key_level_o(lvl1), .key_press_o(pr1), .key_release_o(rl1));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int base = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model, index = inst*2 + key. A change is accepted once the synchronized
  // value has differed from the accepted level on SC+1 consecutive edges.
  // Repeats fall at n = RD, RD+RP, ... edges after the start of an
  // uninterrupted hold.
  logic [1:0] m_s1 = 2'b11, m_s2 = 2'b11;
  int run[4] = '{0, 0, 0, 0};
  int n[4]   = '{0, 0, 0, 0};
  bit lvl_m[4] = '{0, 0, 0, 0};
  bit held[4]  = '{0, 0, 0, 0};
  bit pr_m[4]  = '{0, 0, 0, 0};
  bit rl_m[4]  = '{0, 0, 0, 0};

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_s1 = 2'b11;
      m_s2 = 2'b11;
      for (int i = 0; i < 4; i++) begin
        run[i] = 0; n[i] = 0; lvl_m[i] = 0; held[i] = 0; pr_m[i] = 0; rl_m[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        bit s;
        s = !m_s2[i % 2];
        pr_m[i] = 0;
        rl_m[i] = 0;
        if (s != lvl_m[i]) begin
          run[i]++;
          if (run[i] == SC + 1) begin
            lvl_m[i] = s;
            run[i] = 0;
            if (s) begin
              pr_m[i] = 1; held[i] = 1; n[i] = 0;
            end else begin
              rl_m[i] = 1;
            end
          end else if (lvl_m[i]) begin
            held[i] = 0;
          end
        end else begin
          run[i] = 0;
          if (lvl_m[i]) begin
            if (!held[i]) begin
              held[i] = 1; n[i] = 0;
            end else begin
              n[i]++;
              if (i >= 2 && (n[i] == RD || (n[i] > RD && (n[i] - RD) % RP == 0)))
                pr_m[i] = 1;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = key_n;
    end
  end

  // Pulse logs, relative to base (edge 1 = first edge after base).
  int plog[4][16];
  int rlog[4][16];
  int pn[4] = '{0, 0, 0, 0};
  int rn[4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    logic [5:0] exp_v, act_v;
    for (int inst = 0; inst < 2; inst++) begin
      exp_v = {lvl_m[inst*2+1], lvl_m[inst*2], pr_m[inst*2+1], pr_m[inst*2],
               rl_m[inst*2+1], rl_m[inst*2]};
      act_v = (inst == 0) ? {lvl0, pr0, rl0} : {lvl1, pr1, rl1};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_cmp inst%0d cyc %0d: {lvl,press,rel} got %b expected %b",
                 inst, cyc, act_v, exp_v);
      end
    end
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        logic p, r;
        p = (i < 2) ? pr0[i % 2] : pr1[i % 2];
        r = (i < 2) ? rl0[i % 2] : rl1[i % 2];
        if (p === 1'b1) begin
          if (pn[i] < 16) plog[i][pn[i]] = cyc - base;
          pn[i]++;
        end
        if (r === 1'b1) begin
          if (rn[i] < 16) rlog[i][rn[i]] = cyc - base;
          rn[i]++;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 4; i++) begin
      pn[i] = 0; rn[i] = 0;
      for (int j = 0; j < 16; j++) begin
        plog[i][j] = -1; rlog[i][j] = -1;
      end
    end
    base = cyc;
  endtask

  task automatic wait_n(input int c);
    repeat (c) @(negedge clk);
  endtask

  initial begin
    clear_logs();
    // Reset and idle.
    wait_n(1);
    chk("reset_outputs", int'({lvl0, pr0, rl0, lvl1, pr1, rl1}), 0);
    wait_n(2);
    rst = 1'b0;
    clear_logs();
    wait_n(30);
    chk("idle_no_pulses", pn[0] + pn[1] + pn[2] + pn[3] + rn[0] + rn[1] + rn[2] + rn[3], 0);

    // Single clean press of key 0.
    clear_logs();
    key_n[0] = 1'b0;
    wait_n(40);
    key_n[0] = 1'b1;
    wait_n(20);
    chk("norep_press_count", pn[0], 1);
    chk("norep_press_edge", plog[0][0], 7);
    chk("norep_release_count", rn[0], 1);
    chk("norep_release_edge", rlog[0][0], 47);
    chk("rep_k0_press_count", pn[2], 5);
    chk("rep_k0_first_repeat", plog[2][1], 27);
    chk("rep_k0_release_edge", rlog[2][0], 47);
    wait_n(5);

    // Bouncing key 0, then held low.
    clear_logs();
    for (int j = 0; j < 6; j++) begin
      key_n[0] = j[0];
      wait_n(2);
    end
    key_n[0] = 1'b0;
    wait_n(13);
    key_n[0] = 1'b1;
    wait_n(15);
    chk("bounce_norep_count", pn[0], 1);
    chk("bounce_norep_edge", plog[0][0], 19);
    chk("bounce_rep_edge", plog[2][0], 19);
    chk("bounce_release_count", rn[0], 1);

    // Key 1 held 60 cycles with repeat.
    clear_logs();
    key_n[1] = 1'b0;
    wait_n(60);
    key_n[1] = 1'b1;
    wait_n(15);
    chk("hold_rep_count", pn[3], 9);
    chk("hold_rep_p0", plog[3][0], 7);
    chk("hold_rep_p1", plog[3][1], 27);
    chk("hold_rep_p2", plog[3][2], 32);
    chk("hold_rep_p3", plog[3][3], 37);
    chk("hold_rep_last", plog[3][8], 62);
    chk("hold_norep_count", pn[1], 1);
    chk("hold_k0_quiet", pn[0] + pn[2] + rn[0] + rn[2], 0);

    // Both keys pressed together; 2-cycle glitch on key 0 while held.
    clear_logs();
    key_n = 2'b00;
    wait_n(12);
    key_n[0] = 1'b1;
    wait_n(2);
    key_n[0] = 1'b0;
    wait_n(26);
    key_n = 2'b11;
    wait_n(15);
    chk("simul_k0_first", plog[2][0], 7);
    chk("simul_k1_first", plog[3][0], 7);
    chk("glitch_k0_repeat", plog[2][1], 37);
    chk("glitch_k0_count", pn[2], 3);
    chk("glitch_k1_repeat", plog[3][1], 27);
    chk("glitch_k1_count", pn[3], 5);
    chk("glitch_no_early_release", rlog[0][0], 47);
    chk("glitch_norep_count", pn[0], 1);

    // Reset in the middle of repeat with key 1 held.
    clear_logs();
    key_n[1] = 1'b0;
    wait_n(30);
    chk("pre_reset_level", int'(lvl1[1]), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", int'({lvl0, pr0, rl0, lvl1, pr1, rl1}), 0);
    wait_n(3);
    rst = 1'b0;
    clear_logs();
    wait_n(10);
    chk("post_reset_rep_count", pn[3], 1);
    chk("post_reset_rep_edge", plog[3][0], 7);
    chk("post_reset_norep_edge", plog[1][0], 7);
    key_n[1] = 1'b1;
    wait_n(12);
    chk("post_reset_release", rn[3], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Debounce and event generator for the board push buttons. Takes the raw, active-low `key_i` lines and produces clean debounced levels plus single-cycle press, release and auto-repeat pulses. Downstream blocks (counter, display and menu logic) consume these pulses instead of sampling buttons directly. All keys run independent, identical channels in one clock domain.

## Interface

- `KEYS`, 2: number of button channels.
- `STABLE_CYCLES`, 1_000_000: consecutive stable synchronized samples required to accept a change (10 ms at 100 MHz); minimum 2.
- `REPEAT_EN`, 1: 1 enables auto-repeat while held; 0 means a single press pulse per press.
- `REPEAT_DELAY`, 50_000_000: cycles from accepted press to first repeat pulse; minimum 2.
- `REPEAT_PERIOD`, 10_000_000: cycles between subsequent repeat pulses; minimum 2.

Ports:

- `clk100_i`  in  1  system clock. One clock, single domain.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `key_i`  in  KEYS  raw buttons, active-low (0 = pressed), asynchronous to `clk100_i`.
- `key_level_o`  out  KEYS  debounced state, active-high (1 = pressed).
- `key_press_o`  out  KEYS  one-cycle pulse on accepted press and on each auto-repeat.
- `key_release_o`  out  KEYS  one-cycle pulse on accepted release.

## Operation

- Per channel: 2-FF synchronizer on `key_i[k]`, inverted. Its output is `s` (1 = pressed).
- One counter per channel, wide enough for max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
- FSM per channel, with `cnt` cleared on every state change:
  - IDLE: level 0. If s=1, go to PRESS_WAIT.
  - PRESS_WAIT: if s=0, return to IDLE (bounce rejected, no output). If s=1 and cnt=STABLE_CYCLES-1, go to HELD, set level to 1 and pulse press. Otherwise cnt++.
  - HELD: if s=0, go to RELEASE_WAIT. If REPEAT_EN and cnt=REPEAT_DELAY-1, go to REPEAT and pulse press. Otherwise cnt++ (saturates when REPEAT_EN=0).
  - REPEAT: if s=0, go to RELEASE_WAIT. If cnt=REPEAT_PERIOD-1, pulse press and clear cnt. Otherwise cnt++.
  - RELEASE_WAIT: level stays 1, no repeat pulses. If s=1, go to HELD (repeat delay restarts from 0). If s=0 and cnt=STABLE_CYCLES-1, go to IDLE, set level to 0 and pulse release. Otherwise cnt++.
- All outputs are registered. Press and release pulses are exactly one cycle wide and never both high on the same channel in the same cycle.
- Channels are fully independent. Simultaneous activity on several keys yields simultaneous pulses.

## Timing

- Reset (async, any time, including mid-debounce or mid-repeat):
  - all FSMs go to IDLE and counters clear;
  - synchronizers load 1 (released);
  - `key_level_o`, `key_press_o` and `key_release_o` go to 0 immediately.
- Press latency: edge 1 is the first edge sampling `key_i[k]`=0, held low. `key_level_o[k]` and `key_press_o[k]` assert after edge STABLE_CYCLES+3.
- Release latency is symmetric: `key_release_o[k]` asserts and level falls after edge STABLE_CYCLES+3, counted from the first edge sampling 1.
- First repeat pulse comes REPEAT_DELAY cycles after the initial press pulse. Later repeats come every REPEAT_PERIOD cycles.
- Glitches shorter than STABLE_CYCLES synchronized cycles never change level or generate pulses.
- Key held pressed through reset deassertion: treated as a new press and reported STABLE_CYCLES+3 edges after reset release.

## Test plan

Bench parameters: STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, KEYS=2.

- Reset with `key_i`=2'b11, then release reset and idle for 30 cycles -> all outputs 0 throughout, no pulses.
- `key_i[0]` low for 40 cycles, then high, with REPEAT_EN=0 -> level and press high after edge 7 (one-cycle press); release pulse 7 edges after rise; exactly one press and one release.
- `key_i[0]` toggles every 2 cycles for 12 cycles, then held low -> no output during bouncing; press exactly 7 edges after the last falling edge.
- `key_i[1]` held low 60 cycles, REPEAT_EN=1 -> press pulses after edges 7, 27, 32, 37, …, stopping once RELEASE_WAIT is entered; `key_i[0]` outputs stay 0.
- While HELD, a 2-cycle high glitch on `key_i[0]` -> no release, level stays 1; next repeat comes 20 cycles after return to HELD. Both keys pressed on the same cycle -> identical, simultaneous pulses.
- Assert `rst_i` mid-REPEAT with key held -> outputs go to 0 asynchronously. Deassert with key still low -> new press pulse after edge 7.
